md5_iter_core: RTL and testbench
================================

Name: md5_iter_core

Overview:
- Parametrised iterative MD5 compression engine; successor to the fixed four-round MD5 pipeline.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake and chains multiple blocks per message through an internal chaining register.
- Computes UNROLL of the 64 steps per clock and emits the standard 128-bit digest after the last block.
- Sits between a message padder/packer and the hash consumer.

Parameters:
- UNROLL, default 1: MD5 steps per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NSTEP_CYC, derived as 64/UNROLL: number of compute cycles per block. Not user-overridable.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- blk_valid_i  in  1  a block is offered.
- blk_ready_o  out  1  the core can accept a block.
- blk_i  in  512  message block; word j = blk_i[32j+31:32j], little-endian bytes within each word as MD5 defines.
- blk_first_i  in  1  first block of a message; chaining value H is reloaded with the IV before this block is processed.
- blk_last_i  in  1  last block of a message; a digest is produced after this block.
- digest_valid_o  out  1  one-cycle pulse: digest_o has been updated.
- digest_o  out  128  digest; digest_o[127:120] is digest byte 0 (A byte-swapped, then B, C, D).
- busy_o  out  1  the core is not in IDLE.

Behaviour:
- Reset values:
  - state = IDLE; blk_ready_o = 1 in the cycle after reset releases.
  - digest_valid_o = 0; digest_o = 0; busy_o = 0.
  - H = IV = 67452301, EFCDAB89, 98BADCFE, 10325476; step counter = 0.
- IDLE:
  - blk_ready_o = 1.
  - On a clock edge with blk_valid_i & blk_ready_o:
    - latch blk_i, blk_first_i and blk_last_i;
    - load working registers A..D from IV if first, else from H;
    - if first, H <= IV;
    - go to RUN.
- RUN:
  - blk_ready_o = 0.
  - Each cycle applies steps i .. i+UNROLL-1 through chained md5_step instances, then i += UNROLL.
  - Step i uses the standard F/G/H/I function, message index g(i), K[i] and S[i].
  - When the final group (steps 64-UNROLL .. 63) completes, go to ADD.
- ADD:
  - H <= H + {A,B,C,D}, each word added modulo 2^32; carries are discarded.
  - If last was latched: digest_o <= byte-swapped {H+A, H+B, H+C, H+D} and digest_valid_o = 1 for exactly one cycle (the cycle after ADD).
  - Go to IDLE.
- Latency:
  - With the accepting edge at cycle 0, digest_valid_o is high in cycle NSTEP_CYC+2.
  - blk_ready_o returns high in that same cycle.
  - Block throughput is one block per NSTEP_CYC+2 cycles.
- Ordering and signal behaviour:
  - digest_o holds its value until the next last-block ADD.
  - H persists across blocks until a first block or rst_i.
  - busy_o = (state != IDLE).
- Boundary conditions:
  - blk_valid_i while blk_ready_o = 0: ignored and not buffered. The source holds the block until ready.
  - blk_first_i & blk_last_i on the same block: single-block message.
  - blk_first_i = 0 as the first block after reset: H is already IV, so the result equals a first-flagged block.
  - blk_valid_i dropped without a handshake: no effect.
  - rst_i mid-RUN or mid-ADD: abort immediately, no digest pulse, all reset values restored on the next edge. rst_i has priority over a simultaneous handshake.
  - Step counter wraps only via ADD; a counter value of 64 or more is unreachable.

Decomposition:
- md5_pkg holds:
  - K[0:63] constants (correct RFC 1321 values);
  - S[0:63] rotate amounts;
  - the IV words;
  - function msg_idx(i) → g(i);
  - function round_fn(sel, b, c, d);
  - typedef state_t {IDLE, RUN, ADD};
  - typedef md5_word_t as a 32-bit logic.
- One sub-module, md5_step: purely combinational single MD5 step.
  - Inputs: a, b, c, d, m, k, s, round select.
  - Outputs: next a..d.
  - Instantiated UNROLL times in a generate loop.

Test Plan:
- Empty message: padded block word0 = 00000080, all other words 0 except word14 = 0, first=last=1 → digest D41D8CD98F00B204E9800998ECF8427E, pulse exactly in cycle NSTEP_CYC+2.
- "abc": word0 = 80636261, word14 = 00000018, first=last=1 → 900150983CD24FB0D6963F7D28E17F72. Repeat for UNROLL = 1, 4 and 16 with identical digests.
- Two-block message: 80 ASCII digits "1234567890"×8, blocks sent back-to-back (first, then last) → 57EDF4A22BE3C955AC49DA2E2107B67A. No digest pulse after block 1.
- Backpressure: hold blk_valid_i high with different data during RUN → blk_ready_o = 0 throughout, data ignored, "abc" digest unchanged. The next block is accepted exactly on ready's return.
- Reset mid-RUN: assert rst_i at step-cycle 10 of the "abc" block → no digest_valid_o, digest_o = 0, blk_ready_o = 1 after reset. A resubmitted "abc" block gives the correct digest.
- Chain restart: complete block 1 of the two-block message, then send "abc" with first=1 → "abc" digest (H reloaded from IV).

Source files
------------

// File: rtl/md5_pkg.sv
// MD5 constants, round helpers and shared types for the iterative compression core.
// Pure definitions: no latency and no flow control.
package md5_pkg;

  typedef logic [31:0] md5_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2
  } state_t;

  localparam md5_word_t IV_A = 32'h67452301;
  localparam md5_word_t IV_B = 32'hefcdab89;
  localparam md5_word_t IV_C = 32'h98badcfe;
  localparam md5_word_t IV_D = 32'h10325476;
  localparam logic [127:0] IV = {IV_A, IV_B, IV_C, IV_D};

  localparam md5_word_t K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [0:63] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // Message word index g(i); arithmetic is naturally mod 16 at 4-bit width.
  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    logic [3:0] x;
    logic [3:0] g;
    x = i[3:0];
    unique case (i[5:4])
      2'd0:    g = x;
      2'd1:    g = x * 4'd5 + 4'd1;
      2'd2:    g = x * 4'd3 + 4'd5;
      default: g = x * 4'd7;
    endcase
    return g;
  endfunction

  function automatic md5_word_t round_fn(input logic [1:0] sel, input md5_word_t b,
                                         input md5_word_t c, input md5_word_t d);
    md5_word_t f;
    unique case (sel)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  function automatic md5_word_t bswap(input md5_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: rotates the A..D state by one position.
// Zero latency; no flow control.
module md5_step
  import md5_pkg::*;
(
  input  md5_word_t  a_i,
  input  md5_word_t  b_i,
  input  md5_word_t  c_i,
  input  md5_word_t  d_i,
  input  md5_word_t  m_i,
  input  md5_word_t  k_i,
  input  logic [4:0] s_i,
  input  logic [1:0] sel_i,
  output md5_word_t  a_o,
  output md5_word_t  b_o,
  output md5_word_t  c_o,
  output md5_word_t  d_o
);

  md5_word_t sum;
  md5_word_t rot;

  always_comb begin
    sum = a_i + round_fn(sel_i, b_i, c_i, d_i) + k_i + m_i;
    rot = (sum << s_i) | (sum >> (6'd32 - {1'b0, s_i}));
  end

  assign a_o = d_i;
  assign b_o = b_i + rot;
  assign c_o = b_i;
  assign d_o = c_i;

endmodule

// File: rtl/md5_iter_core.sv
// Iterative MD5 compression: UNROLL steps per cycle, chaining H across blocks of a message.
// Digest pulse NSTEP_CYC+2 cycles after acceptance; ready is low while a block is in flight.
module md5_iter_core
  import md5_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          blk_valid_i,
  output logic          blk_ready_o,
  input  logic [511:0]  blk_i,
  input  logic          blk_first_i,
  input  logic          blk_last_i,
  output logic          digest_valid_o,
  output logic [127:0]  digest_o,
  output logic          busy_o
);

  localparam int NSTEP_CYC = 64 / UNROLL;
  localparam logic [5:0] LAST_GRP = 6'(64 - UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("md5_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
  end

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [511:0]   blk_q, blk_d;
  logic           last_q, last_d;
  md5_word_t      a_q, b_q, c_q, d_q;
  md5_word_t      a_d, b_d, c_d, d_d;
  logic [127:0]   h_q, h_d;
  logic [127:0]   digest_q, digest_d;
  logic           dvld_q, dvld_d;
  logic [127:0]   h_sum;

  md5_word_t ca [UNROLL+1];
  md5_word_t cb [UNROLL+1];
  md5_word_t cc [UNROLL+1];
  md5_word_t cd [UNROLL+1];

  assign ca[0] = a_q;
  assign cb[0] = b_q;
  assign cc[0] = c_q;
  assign cd[0] = d_q;

  // cnt_q is always a multiple of UNROLL, so idx never exceeds 63.
  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    logic [5:0] idx;
    logic [3:0] g;
    md5_word_t  m;
    assign idx = cnt_q + 6'(u);
    assign g   = msg_idx(idx);
    assign m   = blk_q[{g, 5'b0} +: 32];

    md5_step u_step (
      .a_i   (ca[u]),
      .b_i   (cb[u]),
      .c_i   (cc[u]),
      .d_i   (cd[u]),
      .m_i   (m),
      .k_i   (K[idx]),
      .s_i   (S[idx]),
      .sel_i (idx[5:4]),
      .a_o   (ca[u+1]),
      .b_o   (cb[u+1]),
      .c_o   (cc[u+1]),
      .d_o   (cd[u+1])
    );
  end

  assign h_sum = {h_q[127:96] + a_q, h_q[95:64] + b_q, h_q[63:32] + c_q, h_q[31:0] + d_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    h_d      = h_q;
    digest_d = digest_q;
    dvld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (blk_valid_i) begin
          blk_d  = blk_i;
          last_d = blk_last_i;
          cnt_d  = '0;
          if (blk_first_i) begin
            {a_d, b_d, c_d, d_d} = IV;
            h_d = IV;
          end else begin
            {a_d, b_d, c_d, d_d} = h_q;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        a_d = ca[UNROLL];
        b_d = cb[UNROLL];
        c_d = cc[UNROLL];
        d_d = cd[UNROLL];
        // The counter parks on the last group so it never reaches 64.
        if (cnt_q == LAST_GRP) begin
          state_d = ADD;
        end else begin
          cnt_d = cnt_q + 6'(UNROLL);
        end
      end
      ADD: begin
        h_d   = h_sum;
        cnt_d = '0;
        if (last_q) begin
          digest_d = {bswap(h_sum[127:96]), bswap(h_sum[95:64]),
                      bswap(h_sum[63:32]), bswap(h_sum[31:0])};
          dvld_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      a_q      <= IV_A;
      b_q      <= IV_B;
      c_q      <= IV_C;
      d_q      <= IV_D;
      h_q      <= IV;
      digest_q <= '0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      dvld_q   <= dvld_d;
    end
  end

  assign blk_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign digest_valid_o = dvld_q;
  assign digest_o       = digest_q;

endmodule

// File: tb/tb_md5_iter_core.sv
// Scoreboarded bench: driver pushes expected digests and pulse times, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_md5_iter_core;

  localparam int UNROLL    = 1;
  localparam int NSTEP_CYC = 64 / UNROLL;
  localparam logic [127:0] IV        = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DIG_TWO   = 128'h57edf4a22be3c955ac49da2e2107b67a;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          blk_valid_i;
  logic          blk_ready_o;
  logic [511:0]  blk_i;
  logic          blk_first_i;
  logic          blk_last_i;
  logic          digest_valid_o;
  logic [127:0]  digest_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  md5_iter_core #(.UNROLL(UNROLL)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .blk_valid_i    (blk_valid_i),
    .blk_ready_o    (blk_ready_o),
    .blk_i          (blk_i),
    .blk_first_i    (blk_first_i),
    .blk_last_i     (blk_last_i),
    .digest_valid_o (digest_valid_o),
    .digest_o       (digest_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic [127:0] dig;
    time          due;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           errs = 0;
  int           checks = 0;
  logic [127:0] hold = '0;
  logic [127:0] mh = IV;
  time          last_acc = 0;
  logic         x_go = 1'b0;
  logic [511:0] blk_empty, blk_abc, blk_two1, blk_two2;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] digest_of(input logic [127:0] h);
    return {bsw(h[127:96]), bsw(h[95:64]), bsw(h[63:32]), bsw(h[31:0])};
  endfunction

  // Reference compression straight from RFC 1321; K derived from |sin(i+1)|.
  function automatic logic [127:0] md5_model(input logic [127:0] hin, input logic [511:0] b);
    logic [31:0] a, bb, c, d, f, t, k;
    int g, s;
    real r;
    int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    a = hin[127:96]; bb = hin[95:64]; c = hin[63:32]; d = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (bb & c) | (~bb & d); g = i;              end
        1:       begin f = (d & bb) | (~d & c);  g = (5 * i + 1) % 16; end
        2:       begin f = bb ^ c ^ d;           g = (3 * i + 5) % 16; end
        default: begin f = c ^ (bb | ~d);        g = (7 * i) % 16;     end
      endcase
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k = 32'(longint'($floor(r * 4294967296.0)));
      s = sh[(i / 16) * 4 + i % 4];
      t = a + f + k + b[32 * g +: 32];
      a = d; d = c; c = bb;
      bb = bb + ((t << s) | (t >> (32 - s)));
    end
    return {hin[127:96] + a, hin[95:64] + bb, hin[63:32] + c, hin[31:0] + d};
  endfunction

  task automatic send(input logic [511:0] b, input logic f, input logic l,
                      input bit expct, input bit use_kn, input logic [127:0] kn);
    int n;
    exp_t x;
    @(negedge clk_i);
    blk_valid_i = 1'b1; blk_i = b; blk_first_i = f; blk_last_i = l;
    n = 0;
    while (!blk_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (!blk_ready_o) begin
      checks++; errs++;
      $display("FAIL accept_timeout: ready=%0b after %0d cycles, required 1", blk_ready_o, n);
      blk_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    last_acc = $time;
    if (f) mh = IV;
    mh = md5_model(mh, b);
    if (l && expct) begin
      x.dig = use_kn ? kn : digest_of(mh);
      x.due = $time + (NSTEP_CYC + 1) * 10 + 5;
      exp_q.push_back(x);
    end
    @(negedge clk_i);
    blk_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; blk_valid_i = 1'b0;
    exp_q.delete(); hold = '0; mh = IV;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errs++;
      $display("FAIL drain_timeout: %0d digests outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk_i);
  endtask

  // Offers junk only while the core is busy, then withdraws it.
  task automatic blip();
    @(negedge clk_i);
    if (!blk_ready_o) begin
      blk_valid_i = 1'b1;
      for (int w = 0; w < 16; w++) blk_i[32 * w +: 32] = $urandom;
      @(negedge clk_i);
      blk_valid_i = 1'b0;
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("ready_vs_busy", 128'(blk_ready_o), 128'(!busy_o));
      if (digest_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_pulse: got digest %h, required no pulse", digest_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("digest", digest_o, mon_e.dig);
          chk("pulse_time", 128'($time), 128'(mon_e.due));
          hold = mon_e.dig;
        end
      end else begin
        chk("digest_hold", digest_o, hold);
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_alt
    localparam int UN = (gi == 0) ? 4 : 16;
    logic         v, rdy, dv, bsy, done;
    logic [127:0] dg;

    md5_iter_core #(.UNROLL(UN)) u_alt (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .blk_valid_i    (v),
      .blk_ready_o    (rdy),
      .blk_i          (blk_abc),
      .blk_first_i    (1'b1),
      .blk_last_i     (1'b1),
      .digest_valid_o (dv),
      .digest_o       (dg),
      .busy_o         (bsy)
    );

    initial begin
      int n;
      v = 1'b0; done = 1'b0;
      wait (x_go);
      @(negedge clk_i);
      v = 1'b1;
      n = 0;
      while (!rdy && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      @(negedge clk_i);
      v = 1'b0;
      n = 1;
      while (!dv && n < 200) begin
        @(negedge clk_i);
        n++;
      end
      chk($sformatf("alt%0d_latency", UN), 128'(n), 128'(64 / UN + 2));
      chk($sformatf("alt%0d_digest", UN), dg, DIG_ABC);
      @(negedge clk_i);
      chk($sformatf("alt%0d_idle", UN), 128'(bsy), 128'(0));
      done = 1'b1;
    end
  end

  initial begin
    logic [7:0]   pad [128];
    logic [511:0] rb;
    time          t1;
    int           rc, n;
    rst_i = 1'b1; blk_valid_i = 1'b0; blk_first_i = 1'b0; blk_last_i = 1'b0; blk_i = '0;

    blk_empty = '0; blk_empty[31:0] = 32'h00000080;
    blk_abc = '0; blk_abc[31:0] = 32'h80636261; blk_abc[14 * 32 +: 32] = 32'h00000018;
    for (int i = 0; i < 128; i++) pad[i] = 8'h00;
    for (int i = 0; i < 80; i++) pad[i] = 8'h30 + 8'((i + 1) % 10);
    pad[80] = 8'h80; pad[120] = 8'h80; pad[121] = 8'h02;
    for (int j = 0; j < 64; j++) begin
      blk_two1[8 * j +: 8] = pad[j];
      blk_two2[8 * j +: 8] = pad[64 + j];
    end

    do_reset();
    chk("rst_ready", 128'(blk_ready_o), 128'(1));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_dvld", 128'(digest_valid_o), 128'(0));
    chk("rst_digest", digest_o, '0);

    send(blk_empty, 1'b1, 1'b1, 1'b1, 1'b1, DIG_EMPTY);
    wait_drain();
    send(blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_drain();

    send(blk_two1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    send(blk_two2, 1'b0, 1'b1, 1'b1, 1'b1, DIG_TWO);
    wait_drain();

    // Second block is held valid throughout the first's RUN.
    for (int w = 0; w < 16; w++) rb[32 * w +: 32] = $urandom;
    send(blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, DIG_ABC);
    t1 = last_acc;
    send(rb, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("accept_on_ready", 128'(last_acc - t1), 128'((NSTEP_CYC + 2) * 10));
    wait_drain();

    rc = (NSTEP_CYC > 12) ? 10 : NSTEP_CYC / 2;
    send(blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (rc - 1) @(negedge clk_i);
    do_reset();
    chk("midrun_ready", 128'(blk_ready_o), 128'(1));
    chk("midrun_busy", 128'(busy_o), 128'(0));
    chk("midrun_digest", digest_o, '0);
    repeat (NSTEP_CYC + 4) @(negedge clk_i);
    send(blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_drain();

    send(blk_two1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    send(blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_drain();

    do_reset();
    send(blk_abc, 1'b0, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_drain();

    for (int msg = 0; msg < 12; msg++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        for (int w = 0; w < 16; w++) rb[32 * w +: 32] = $urandom;
        send(rb, (k == 0) ? ($urandom_range(0, 3) != 0) : 1'b0, k == n - 1, 1'b1, 1'b0, '0);
        if ($urandom_range(0, 1) == 1) blip();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    wait_drain();

    do_reset();
    x_go = 1'b1;
    n = 0;
    while (!(g_alt[0].done && g_alt[1].done) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (!(g_alt[0].done && g_alt[1].done)) begin
      checks++; errs++;
      $display("FAIL alt_timeout: done=%0b%0b, required 11", g_alt[1].done, g_alt[0].done);
    end

    repeat (NSTEP_CYC + 6) @(negedge clk_i);
    chk("no_outstanding", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
